// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - variable-amount shift/rotate sequencer built on a single-step op2bit unit
// One op2bit step is applied per clock while in SHIFT; start/busy/done handshake wraps it.

module op2bit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sra,
  input  logic             rotate,
  input  logic             op,
  output logic [WIDTH-1:0] out1
);
  always_comb begin
    out1 = a;
    if (op) begin
      if (rotate)   out1 = {a[0], a[WIDTH-1:1]};
      else if (sra) out1 = {a[WIDTH-1], a[WIDTH-1:1]};
      else          out1 = {1'b0, a[WIDTH-1:1]};
    end
  end
endmodule

module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sra,
  input  logic             rotate,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] data_r;
  logic [SHW-1:0]   cnt;
  logic             sra_r;
  logic             rotate_r;
  logic             step_en;
  logic [WIDTH-1:0] out1;

  assign step_en = (state == SHIFT);
  assign busy    = (state != IDLE);

  op2bit #(.WIDTH(WIDTH)) u_step (
    .a      (data_r),
    .sra    (sra_r),
    .rotate (rotate_r),
    .op     (step_en),
    .out1   (out1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_r   <= '0;
      cnt      <= '0;
      sra_r    <= 1'b0;
      rotate_r <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_r   <= a;
            cnt      <= shamt;
            sra_r    <= sra;
            rotate_r <= rotate;
            if (shamt == '0) begin
              // Zero amount: result is the operand itself, no step taken.
              result <= a;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data_r <= out1;
          if (cnt != '0) cnt <= cnt - 1'b1;
          // Capture the final step's output so result is valid with done.
          if (cnt == SHW'(1)) begin
            result <= out1;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that realises variable-amount shifts and rotates by iterating the single-step shift unit `op2bit` one bit position per clock. It accepts a 32-bit operand, a mode and a 5-bit shift amount, then drives `op2bit`'s `sra`/`rotate`/`op` controls and feeds its `out1` back into an internal operand register. It sits between the ALU control path and `op2bit` and owns the start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand/result width; equals `op2bit` data width.
- `SHW`, 5, shift-amount width; `2**SHW == WIDTH`.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `sra`  in  1  arithmetic-right select; latched on accept.
- `rotate`  in  1  rotate-right select, overrides `sra`; latched on accept.
- `a`  in  WIDTH  operand; latched on accept.
- `shamt`  in  SHW  number of one-bit steps, 0..31; latched on accept.
- `busy`  out  1  high in SHIFT and DONE.
- `done`  out  1  one-cycle pulse, result valid.
- `result`  out  WIDTH  registered result, held until next accept.

## Operation
- Instantiates one `op2bit`; its `a` = internal `data_r`, `sra`/`rotate` = latched `sra_r`/`rotate_r`, `op` = 1 only in SHIFT, else 0 (pass-through).
- Step semantics per enabled cycle: rotate=1 → rotate right by 1; rotate=0,sra=1 → arithmetic right by 1 (MSB replicated); both 0 → logical right by 1 (zero fill).
- FSM states IDLE, SHIFT, DONE.
  - IDLE: on `start`=1, latch `data_r`←`a`, `cnt`←`shamt`, `sra_r`, `rotate_r`; go SHIFT if `shamt`≠0, else DONE.
  - SHIFT: each edge `data_r`←`out1`, `cnt`←`cnt`−1; when `cnt`==1 go DONE.
  - DONE: `done`=1 for this cycle only; `result`←`data_r` at the DONE-entry edge. Next edge → IDLE unconditionally.
- `start` while `busy`=1 is ignored; the request is not queued.
- Inputs other than `start` are don't-care outside the accept edge.
- `cnt` is SHW bits, never underflows: decrement only in SHIFT with `cnt`≥1.
- `shamt`=31 with rotate is a rotate left by 1; no special casing.

## Timing
- Reset (async assert, sync-free release): state IDLE, `busy`=0, `done`=0, `result`=0, `data_r`=0, `cnt`=0, `sra_r`=`rotate_r`=0.
- Reset asserted mid-SHIFT or in DONE aborts immediately; no `done` pulse; `result` cleared to 0.
- Accept at edge E: `busy` high from E. `shamt`=n≥1: n shift edges E+1..E+n, `done` high in the cycle after E+n, i.e. `done` visible n+1 cycles after accept. `shamt`=0: `done` high in the cycle after E.
- `busy` falls at the edge ending DONE; `start` may be accepted in that following IDLE cycle. Minimum request spacing: n+2 cycles.
- `result` updates only at DONE entry; stable across IDLE and during the next operation until its DONE.
- All outputs registered except `busy` (decode of state register, glitch-free).

## Test plan
- Logical: `a`=0x12345678, sra=0, rotate=0, `shamt`=4 → `done` 5 cycles after accept, `result`=0x01234567, `busy` high exactly 5 cycles.
- Arithmetic: `a`=0x87654321, sra=1, rotate=0, `shamt`=8 → `result`=0xFF876543 after 9 cycles.
- Rotate (sra=1 ignored): `a`=0xFEDCBA98, rotate=1, `shamt`=4 → 0x8FEDCBA9; `a`=0xABCDEFFF, rotate=1, `shamt`=31 → 0x579BDFFF after 32 cycles.
- Zero amount: `a`=0xC0FFEE01, `shamt`=0 → `done` the cycle after accept, `result`=0xC0FFEE01; `op` never asserted.
- Busy reject: accept `a`=0xF0F0F0F0 logical `shamt`=4, pulse `start` with `a`=0xFFFFFFFF mid-SHIFT → single `done`, `result`=0x0F0F0F0F; back-to-back `start` held high re-accepts in IDLE after DONE.
- Reset mid-op: accept `a`=0x98765432 sra `shamt`=16, drop `rst_n` at step 3 → `busy`,`done`,`result` immediately 0; after release, new op completes normally.
